// File: rtl/mux2to1_arbiter_if.sv
// Bus between two requesters and the 2:1 arbitrated mux.
// The slave modport is the arbiter side and the master modport is the requester side.
interface mux2to1_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_vld;

  modport slave (
    input  req0, req1, in0, in1,
    output gnt0, gnt1, sel, out, out_vld
  );

  modport master (
    output req0, req1, in0, in1,
    input  gnt0, gnt1, sel, out, out_vld
  );
endinterface

// File: rtl/mux2to1_arbiter.sv
// Two-requester round-robin arbiter that owns the select line of a registered 2:1 mux.
// A hold limit forces a handoff when the other side has been waiting.
module mux2to1_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux2to1_arbiter_if.slave   bus
);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_hold_cnt;
  logic             r_last;
  logic             r_sel;
  logic [WIDTH-1:0] r_out;
  logic             r_out_vld;
  logic             w_hold_max;
  logic             w_enter0;
  logic             w_enter1;
  logic             w_gnt0;
  logic             w_gnt1;

  assign w_hold_max = (r_hold_cnt == CW'(MAX_HOLD - 1));
  assign w_enter0   = (w_state_next == OWN0) && (r_state != OWN0);
  assign w_enter1   = (w_state_next == OWN1) && (r_state != OWN1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        // r_last names the previous owner, so a tie goes to the other side
        if (bus.req0 && bus.req1) begin
          w_state_next = r_last ? OWN0 : OWN1;
        end else if (bus.req0) begin
          w_state_next = OWN0;
        end else if (bus.req1) begin
          w_state_next = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          w_state_next = bus.req1 ? OWN1 : IDLE;
        end else if (bus.req1 && w_hold_max) begin
          w_state_next = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          w_state_next = bus.req0 ? OWN0 : IDLE;
        end else if (bus.req0 && w_hold_max) begin
          w_state_next = OWN0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_gnt0 = (r_state == OWN0);
    w_gnt1 = (r_state == OWN1);
  end

  // Saturating the count lets a lone requester keep the grant indefinitely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
    end else begin
      if (w_state_next == IDLE || w_enter0 || w_enter1) begin
        r_hold_cnt <= '0;
      end else if (!w_hold_max) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      if (w_enter0) begin
        r_last <= 1'b0;
        r_sel  <= 1'b0;
      end else if (w_enter1) begin
        r_last <= 1'b1;
        r_sel  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (w_gnt0) begin
      r_out     <= bus.in0;
      r_out_vld <= 1'b1;
    end else if (w_gnt1) begin
      r_out     <= bus.in1;
      r_out_vld <= 1'b1;
    end else begin
      r_out_vld <= 1'b0;
    end
  end

  assign bus.gnt0    = w_gnt0;
  assign bus.gnt1    = w_gnt1;
  assign bus.sel     = r_sel;
  assign bus.out     = r_out;
  assign bus.out_vld = r_out_vld;
endmodule
